// File: rtl/counter_scheduler.sv
// Two-requester round-robin command sequencer driving an external saturating
// up/down counter through Load/Up/Down strobes, with a one-cycle completion report.
module counter_scheduler #(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Req0_Valid,
   input  logic [1:0]       Req0_Op,
   input  logic [WIDTH-1:0] Req0_Arg,
   output logic             Req0_Ready,
   input  logic             Req1_Valid,
   input  logic [1:0]       Req1_Op,
   input  logic [WIDTH-1:0] Req1_Arg,
   output logic             Req1_Ready,
   output logic             Done,
   output logic             Done_Id,
   output logic             Done_Sat,
   output logic             Busy,
   output logic             Cnt_Load,
   output logic             Cnt_Up,
   output logic             Cnt_Down,
   output logic [WIDTH-1:0] Cnt_In,
   input  logic [WIDTH-1:0] Cnt_Value,
   input  logic             Cnt_High,
   input  logic             Cnt_Low
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_GOTO = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_DONE
   } state_t;

   state_t           state_reg;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] arg_reg;
   logic [WIDTH-1:0] rem_reg;
   logic             id_reg;
   logic             sat_reg;
   logic             done_reg;
   logic             busy_reg;
   logic             rr_last_reg;

   logic             grant_id;
   logic             accept;
   logic [1:0]       grant_op;
   logic [WIDTH-1:0] grant_arg;

   logic             step_up;
   logic             step_down;
   logic             step_finish;
   logic             step_sat;

   // Contention goes to whichever requester was not granted last.
   always_comb begin
      grant_id = Req1_Valid;
      if (Req0_Valid && Req1_Valid)
         grant_id = ~rr_last_reg;
      accept     = (state_reg == S_IDLE) && (Req0_Valid || Req1_Valid);
      grant_op   = grant_id ? Req1_Op  : Req0_Op;
      grant_arg  = grant_id ? Req1_Arg : Req0_Arg;
      Req0_Ready = accept && !grant_id;
      Req1_Ready = accept &&  grant_id;
   end

   always_comb begin
      step_up     = 1'b0;
      step_down   = 1'b0;
      step_finish = 1'b0;
      step_sat    = 1'b0;
      case (op_reg)
         OP_UP: begin
            if (rem_reg == '0) begin
               step_finish = 1'b1;
            end else if (Cnt_High) begin
               step_finish = 1'b1;
               step_sat    = 1'b1;
            end else begin
               step_up = 1'b1;
            end
         end
         OP_DOWN: begin
            if (rem_reg == '0) begin
               step_finish = 1'b1;
            end else if (Cnt_Low) begin
               step_finish = 1'b1;
               step_sat    = 1'b1;
            end else begin
               step_down = 1'b1;
            end
         end
         OP_GOTO: begin
            if (Cnt_Value == arg_reg)
               step_finish = 1'b1;
            else if (Cnt_Value < arg_reg)
               step_up = 1'b1;
            else
               step_down = 1'b1;
         end
         default: step_finish = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= S_IDLE;
         op_reg      <= OP_LOAD;
         arg_reg     <= '0;
         rem_reg     <= '0;
         id_reg      <= 1'b0;
         sat_reg     <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         rr_last_reg <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  op_reg      <= grant_op;
                  arg_reg     <= grant_arg;
                  rem_reg     <= grant_arg;
                  id_reg      <= grant_id;
                  rr_last_reg <= grant_id;
                  sat_reg     <= 1'b0;
                  busy_reg    <= 1'b1;
                  state_reg   <= (grant_op == OP_LOAD) ? S_LOAD : S_STEP;
               end
            end
            S_LOAD: begin
               done_reg  <= 1'b1;
               state_reg <= S_DONE;
            end
            S_STEP: begin
               if (step_finish) begin
                  sat_reg   <= step_sat;
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else if (op_reg != OP_GOTO) begin
                  rem_reg <= rem_reg - WIDTH'(1);
               end
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign Cnt_Load = (state_reg == S_LOAD);
   assign Cnt_Up   = (state_reg == S_STEP) && step_up;
   assign Cnt_Down = (state_reg == S_STEP) && step_down;
   assign Cnt_In   = arg_reg;
   assign Done     = done_reg;
   assign Done_Id  = id_reg;
   assign Done_Sat = sat_reg;
   assign Busy     = busy_reg;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: behavioural saturating counter, command table,
// scoreboard of expected completions checked when Done pulses.
`timescale 1ns/1ps
module tb_counter_scheduler;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_GOTO = 2'b11;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Req0_Valid = 1'b0, Req1_Valid = 1'b0;
   logic [1:0] Req0_Op = '0, Req1_Op = '0;
   logic [4:0] Req0_Arg = '0, Req1_Arg = '0;
   logic       Req0_Ready, Req1_Ready;
   logic       Done, Done_Id, Done_Sat, Busy;
   logic       Cnt_Load, Cnt_Up, Cnt_Down;
   logic [4:0] Cnt_In;
   logic [4:0] cnt_q = '0;
   logic       Cnt_High, Cnt_Low;

   always #5 CLK = ~CLK;

   counter_scheduler #(.WIDTH(5)) dut (
      .CLK(CLK), .RST(RST),
      .Req0_Valid(Req0_Valid), .Req0_Op(Req0_Op), .Req0_Arg(Req0_Arg), .Req0_Ready(Req0_Ready),
      .Req1_Valid(Req1_Valid), .Req1_Op(Req1_Op), .Req1_Arg(Req1_Arg), .Req1_Ready(Req1_Ready),
      .Done(Done), .Done_Id(Done_Id), .Done_Sat(Done_Sat), .Busy(Busy),
      .Cnt_Load(Cnt_Load), .Cnt_Up(Cnt_Up), .Cnt_Down(Cnt_Down), .Cnt_In(Cnt_In),
      .Cnt_Value(cnt_q), .Cnt_High(Cnt_High), .Cnt_Low(Cnt_Low)
   );

   // Attached counter: Load over Down over Up, saturating at both ends.
   assign Cnt_High = (cnt_q == 5'd31);
   assign Cnt_Low  = (cnt_q == 5'd0);
   always @(posedge CLK) begin
      if (Cnt_Load)
         cnt_q <= Cnt_In;
      else if (Cnt_Down && !Cnt_Low)
         cnt_q <= cnt_q - 5'd1;
      else if (Cnt_Up && !Cnt_High)
         cnt_q <= cnt_q + 5'd1;
   end

   typedef struct {
      logic       id;
      logic [1:0] op;
      logic [4:0] arg;
      logic [4:0] val;
      logic       sat;
      int         strb;
      int         lat;
   } vec_t;

   typedef struct {
      logic       id;
      logic [4:0] val;
      logic       sat;
      int         strb;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[15];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int acc_total = 0;
   int acc_cyc = 0;
   int strobe_cnt = 0;
   bit in_cmd = 0;
   bit busy_chk = 0;
   logic [4:0] cur_arg = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: accepts, strobe counting, and scoreboard comparison on Done.
   always @(negedge CLK) begin
      exp_t e;
      cyc++;
      if (RST) begin
         in_cmd   = 0;
         busy_chk = 0;
      end else begin
         if (Cnt_Load || Cnt_Up || Cnt_Down) begin
            check("strobe_onehot", int'(Cnt_Load) + int'(Cnt_Up) + int'(Cnt_Down), 1);
            if (in_cmd) strobe_cnt++;
         end
         if (Cnt_Load && in_cmd)
            check("cnt_in", Cnt_In, cur_arg);
         if (busy_chk) begin
            check("busy_after_accept", Busy, 1);
            busy_chk = 0;
         end
         if (Done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               $display("txn id=%0d val=%0d sat=%0d strobes=%0d lat=%0d",
                        Done_Id, cnt_q, Done_Sat, strobe_cnt, cyc - acc_cyc);
               check("done_id", Done_Id, e.id);
               check("done_val", cnt_q, e.val);
               check("done_sat", Done_Sat, e.sat);
               check("done_strobes", strobe_cnt, e.strb);
               check("done_latency", cyc - acc_cyc, e.lat);
            end
            in_cmd = 0;
         end
         if (Req0_Ready || Req1_Ready) begin
            check("ready_single", int'(Req0_Ready) + int'(Req1_Ready), 1);
            check("ready_not_busy", Busy, 0);
         end
         if ((Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready)) begin
            in_cmd     = 1;
            busy_chk   = 1;
            acc_cyc    = cyc;
            strobe_cnt = 0;
            cur_arg    = Req1_Ready ? Req1_Arg : Req0_Arg;
            acc_total++;
         end
      end
   end

   task automatic set_req(input logic id, input logic v, input logic [1:0] op, input logic [4:0] arg);
      if (id) begin
         Req1_Valid = v; Req1_Op = op; Req1_Arg = arg;
      end else begin
         Req0_Valid = v; Req0_Op = op; Req0_Arg = arg;
      end
   endtask

   task automatic push_exp(input logic id, input logic [4:0] val, input logic sat, input int strb, input int lat);
      exp_t e;
      e.id = id; e.val = val; e.sat = sat; e.strb = strb; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic id, input logic [1:0] op, input logic [4:0] arg);
      int start_acc = acc_total;
      int n = 0;
      @(posedge CLK); #1;
      set_req(id, 1'b1, op, arg);
      while (acc_total == start_acc && n < 100) begin
         @(negedge CLK); #1;
         n++;
      end
      if (acc_total == start_acc) check("accept_timeout", 0, 1);
      @(posedge CLK); #1;
      set_req(id, 1'b0, op, arg);
   endtask

   task automatic wait_dones(input int target);
      int n = 0;
      while (done_cnt < target && n < 200) begin
         @(negedge CLK); #1;
         n++;
      end
      if (done_cnt < target) check("done_timeout", done_cnt, target);
   endtask

   task automatic issue_pair(input logic [1:0] op0, input logic [4:0] arg0,
                             input logic [1:0] op1, input logic [4:0] arg1);
      bit d0 = 0, d1 = 0, a0, a1;
      int n = 0;
      @(posedge CLK); #1;
      set_req(1'b0, 1'b1, op0, arg0);
      set_req(1'b1, 1'b1, op1, arg1);
      while (!(d0 && d1) && n < 200) begin
         @(negedge CLK); #1;
         a0 = Req0_Valid && Req0_Ready;
         a1 = Req1_Valid && Req1_Ready;
         @(posedge CLK); #1;
         if (a0) begin set_req(1'b0, 1'b0, op0, arg0); d0 = 1; end
         if (a1) begin set_req(1'b1, 1'b0, op1, arg1); d1 = 1; end
         n++;
      end
      if (!(d0 && d1)) check("pair_timeout", 0, 1);
   endtask

   initial begin
      int base;
      int n;
      vecs[0]  = '{1'b0, OP_LOAD, 5'd5,  5'd5,  1'b0, 1,  2};
      vecs[1]  = '{1'b1, OP_DOWN, 5'd8,  5'd0,  1'b1, 5,  7};
      vecs[2]  = '{1'b0, OP_UP,   5'd0,  5'd0,  1'b0, 0,  2};
      vecs[3]  = '{1'b1, OP_DOWN, 5'd0,  5'd0,  1'b0, 0,  2};
      vecs[4]  = '{1'b0, OP_GOTO, 5'd27, 5'd27, 1'b0, 27, 29};
      vecs[5]  = '{1'b1, OP_UP,   5'd2,  5'd29, 1'b0, 2,  4};
      vecs[6]  = '{1'b0, OP_UP,   5'd5,  5'd31, 1'b1, 2,  4};
      vecs[7]  = '{1'b1, OP_GOTO, 5'd27, 5'd27, 1'b0, 4,  6};
      vecs[8]  = '{1'b0, OP_GOTO, 5'd27, 5'd27, 1'b0, 0,  2};
      vecs[9]  = '{1'b1, OP_DOWN, 5'd3,  5'd24, 1'b0, 3,  5};
      vecs[10] = '{1'b0, OP_LOAD, 5'd31, 5'd31, 1'b0, 1,  2};
      vecs[11] = '{1'b1, OP_UP,   5'd1,  5'd31, 1'b1, 0,  2};
      vecs[12] = '{1'b0, OP_LOAD, 5'd0,  5'd0,  1'b0, 1,  2};
      vecs[13] = '{1'b1, OP_DOWN, 5'd1,  5'd0,  1'b1, 0,  2};
      vecs[14] = '{1'b0, OP_LOAD, 5'd0,  5'd0,  1'b0, 1,  2};

      repeat (3) @(posedge CLK);
      @(negedge CLK); #1;
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_done_id", Done_Id, 0);
      check("rst_done_sat", Done_Sat, 0);
      check("rst_strobes", int'(Cnt_Load) + int'(Cnt_Up) + int'(Cnt_Down), 0);
      check("rst_cnt_in", Cnt_In, 0);
      check("rst_ready", int'(Req0_Ready) + int'(Req1_Ready), 0);
      @(posedge CLK); #1;
      RST = 1'b0;

      for (int i = 0; i < 15; i++) begin
         base = done_cnt;
         push_exp(vecs[i].id, vecs[i].val, vecs[i].sat, vecs[i].strb, vecs[i].lat);
         issue(vecs[i].id, vecs[i].op, vecs[i].arg);
         wait_dones(base + 1);
      end

      // Req0 was granted last, so Req1's LOAD goes first; Req0 then saturates at 31.
      base = done_cnt;
      push_exp(1'b1, 5'd29, 1'b0, 1, 2);
      push_exp(1'b0, 5'd31, 1'b1, 2, 4);
      issue_pair(OP_UP, 5'd3, OP_LOAD, 5'd29);
      wait_dones(base + 2);

      base = done_cnt;
      push_exp(1'b0, 5'd10, 1'b0, 1, 2);
      issue(1'b0, OP_LOAD, 5'd10);
      wait_dones(base + 1);

      // Abort UP_N 10 with reset after three strobes.
      base = done_cnt;
      issue(1'b1, OP_UP, 5'd10);
      n = 0;
      while (strobe_cnt < 3 && n < 50) begin
         @(negedge CLK); #1;
         n++;
      end
      check("abort_strobes_seen", strobe_cnt, 3);
      RST = 1'b1;
      @(negedge CLK); #1;
      check("abort_strobes_low", int'(Cnt_Load) + int'(Cnt_Up) + int'(Cnt_Down), 0);
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      #1;
      check("abort_no_done", done_cnt, base);
      check("abort_cnt_hold", cnt_q, 13);
      check("abort_idle", Busy, 0);

      // After reset the pointer favours Req0.
      base = done_cnt;
      push_exp(1'b0, 5'd5, 1'b0, 8, 10);
      push_exp(1'b1, 5'd20, 1'b0, 1, 2);
      issue_pair(OP_GOTO, 5'd5, OP_LOAD, 5'd20);
      wait_dones(base + 2);

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
